// File: rtl/lc3_dmem_if.sv
// LC3 data-memory request/response bundle between the MemAccess stage (master)
// and the memory responder (slave).
interface lc3_dmem_if #(
   parameter int unsigned DATA_W = 16
);
   logic              Data_req;
   logic              Data_rd;
   logic [15:0]       Data_addr;
   logic [DATA_W-1:0] Data_din;
   logic [DATA_W-1:0] Data_dout;
   logic              complete_data;
   logic              busy;
   logic              access_err;

   modport master (
      output Data_req, Data_rd, Data_addr, Data_din,
      input  Data_dout, complete_data, busy, access_err
   );

   modport slave (
      input  Data_req, Data_rd, Data_addr, Data_din,
      output Data_dout, complete_data, busy, access_err
   );
endinterface

// File: rtl/lc3_dmem_responder.sv
// LC3 dmem responder: word-addressed RAM that answers one load/store at a time
// after a fixed number of wait states, flagging accesses beyond the RAM depth.
module lc3_dmem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   lc3_dmem_if.slave   bus
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rd_q;
   logic [15:0]        addr_q;
   logic [DATA_W-1:0]  din_q;
   logic [DATA_W-1:0]  dout_q;
   logic               complete_q;
   logic               busy_q;
   logic               err_q;
   logic               capture_c;
   logic               wr_en_c;
   logic               req_rd_c;
   logic [15:0]        req_addr_c;
   logic [DATA_W-1:0]  req_din_c;
   logic               in_rng_req_c;
   logic               in_rng_q_c;

   logic [DATA_W-1:0]  mem [DEPTH];

   // With zero wait states the write commits on the capture edge, so the
   // request fields come straight from the bus while still in IDLE.
   assign req_rd_c   = (state_q == ST_IDLE) ? bus.Data_rd   : rd_q;
   assign req_addr_c = (state_q == ST_IDLE) ? bus.Data_addr : addr_q;
   assign req_din_c  = (state_q == ST_IDLE) ? bus.Data_din  : din_q;

   if (ADDR_W < 16) begin : g_range
      assign in_rng_req_c = (req_addr_c[15:ADDR_W] == '0);
      assign in_rng_q_c   = (addr_q[15:ADDR_W] == '0);
   end else begin : g_full
      assign in_rng_req_c = 1'b1;
      assign in_rng_q_c   = 1'b1;
   end

   // Next-state and request-capture decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Data_req) begin
               capture_c = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign wr_en_c = (state_d == ST_RESP) && (state_q != ST_RESP) &&
                    !req_rd_c && in_rng_req_c;

   // State, request capture and registered responses
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         dout_q     <= '0;
         complete_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         if (capture_c) begin
            rd_q   <= bus.Data_rd;
            addr_q <= bus.Data_addr;
            din_q  <= bus.Data_din;
         end
         complete_q <= (state_q == ST_RESP);
         err_q      <= (state_q == ST_RESP) && !in_rng_q_c;
         busy_q     <= (state_d != ST_IDLE);
         if ((state_q == ST_RESP) && rd_q) begin
            dout_q <= in_rng_q_c ? mem[addr_q[ADDR_W-1:0]] : '0;
         end
      end
   end

   // RAM write port; contents survive reset, but a reset edge blocks the commit
   always_ff @(posedge clock) begin
      if (reset && wr_en_c) begin
         mem[req_addr_c[ADDR_W-1:0]] <= req_din_c;
      end
   end

   assign bus.Data_dout     = dout_q;
   assign bus.complete_data = complete_q;
   assign bus.busy          = busy_q;
   assign bus.access_err    = err_q;
endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Scoreboard bench for lc3_dmem_responder: four instances with different wait
// counts, directed loads/stores, a negedge monitor checking every completion.
module tb_lc3_dmem_responder;
   typedef struct {
      int          id;
      logic [15:0] dout;
      logic        err;
      int          cyc;
      int          blen;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n [4];
   logic        req   [4];
   logic        rd    [4];
   logic [15:0] addr  [4];
   logic [15:0] din   [4];
   logic [15:0] dout  [4];
   logic        comp  [4];
   logic        busy  [4];
   logic        err   [4];
   int          blen  [4];
   int          cyc    = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        q [$];
   exp_t        e;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic int wcyc(input int d);
      case (d)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 4;
      endcase
   endfunction

   lc3_dmem_if bus [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_dut
      assign bus[g].Data_req  = req[g];
      assign bus[g].Data_rd   = rd[g];
      assign bus[g].Data_addr = addr[g];
      assign bus[g].Data_din  = din[g];
      assign dout[g] = bus[g].Data_dout;
      assign comp[g] = bus[g].complete_data;
      assign busy[g] = bus[g].busy;
      assign err[g]  = bus[g].access_err;

      lc3_dmem_responder #(
         .ADDR_W     (8),
         .DATA_W     (16),
         .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 4)
      ) u_dut (
         .clock(clock),
         .reset(rst_n[g]),
         .bus  (bus[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every completion pulse must match the oldest expectation
   always @(negedge clock) begin
      for (int d = 0; d < 4; d++) begin
         if (comp[d] === 1'b1) begin
            if (q.size() == 0 || q[0].id != d) begin
               checks++;
               errors++;
               $display("FAIL unexpected_complete dut%0d: got pulse at cycle %0d, expected none", d, cyc);
            end else begin
               e = q.pop_front();
               chk($sformatf("dut%0d_dout", d), 32'(dout[d]), 32'(e.dout));
               chk($sformatf("dut%0d_access_err", d), 32'(err[d]), 32'(e.err));
               chk($sformatf("dut%0d_latency", d), 32'(cyc), 32'(e.cyc));
               chk($sformatf("dut%0d_busy_len", d), 32'(blen[d]), 32'(e.blen));
            end
         end
         blen[d] = (busy[d] === 1'b1) ? blen[d] + 1 : 0;
      end
   end

   task automatic wait_drain(input int d);
      int n = 0;
      while ((q.size() != 0 || busy[d] !== 1'b0) && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk($sformatf("dut%0d_drain_timeout", d), 32'(n < 40), 32'd1);
   endtask

   task automatic issue(input int d, input logic is_rd, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_dout,
                        input logic exp_err);
      exp_t x;
      @(negedge clock);
      req[d] = 1'b1; rd[d] = is_rd; addr[d] = a; din[d] = wd;
      x.id = d; x.dout = exp_dout; x.err = exp_err;
      x.cyc = cyc + wcyc(d) + 2; x.blen = wcyc(d) + 1;
      q.push_back(x);
      @(negedge clock);
      req[d] = 1'b0;
      rd[d] = 1'($urandom); addr[d] = 16'($urandom); din[d] = 16'($urandom);
      wait_drain(d);
   endtask

   task automatic chk_idle(input int d, input logic [15:0] exp_dout);
      chk($sformatf("dut%0d_idle_dout", d), 32'(dout[d]), 32'(exp_dout));
      chk($sformatf("dut%0d_idle_complete", d), 32'(comp[d]), 32'd0);
      chk($sformatf("dut%0d_idle_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("dut%0d_idle_err", d), 32'(err[d]), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t x;
      for (int d = 0; d < 4; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; rd[d] = 1'b0;
         addr[d] = 16'h0; din[d] = 16'h0; blen[d] = 0;
      end
      repeat (3) @(negedge clock);
      for (int d = 0; d < 4; d++) chk_idle(d, 16'h0000);
      for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;

      // WAIT_CYCLES=1: write then read back
      issue(0, 1'b0, 16'h0012, 16'hBEEF, 16'h0000, 1'b0);
      issue(0, 1'b1, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);

      // Out-of-range store/load must not alias onto RAM[0x05]
      issue(0, 1'b0, 16'h0005, 16'h5555, 16'hBEEF, 1'b0);
      issue(0, 1'b0, 16'h0105, 16'hAAAA, 16'hBEEF, 1'b1);
      issue(0, 1'b1, 16'h0005, 16'h0000, 16'h5555, 1'b0);
      issue(0, 1'b1, 16'h0105, 16'h0000, 16'h0000, 1'b1);

      // Load data holds across a later store
      issue(0, 1'b0, 16'h0003, 16'h7777, 16'h0000, 1'b0);
      issue(0, 1'b1, 16'h0003, 16'h0000, 16'h7777, 1'b0);
      issue(0, 1'b0, 16'h0004, 16'h1111, 16'h7777, 1'b0);
      repeat (3) @(negedge clock);
      chk_idle(0, 16'h7777);
      issue(0, 1'b1, 16'h0004, 16'h0000, 16'h1111, 1'b0);

      // WAIT_CYCLES=0: top-of-RAM address, then neighbour at wrap point
      issue(1, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 1'b0);
      issue(1, 1'b1, 16'h00FF, 16'h0000, 16'h1234, 1'b0);
      issue(1, 1'b0, 16'h0000, 16'h5A5A, 16'h1234, 1'b0);
      issue(1, 1'b1, 16'h00FF, 16'h0000, 16'h1234, 1'b0);
      issue(1, 1'b1, 16'h0000, 16'h0000, 16'h5A5A, 1'b0);

      // WAIT_CYCLES=3: Data_req held for 6 edges serves exactly two requests
      issue(2, 1'b0, 16'h0001, 16'h0101, 16'h0000, 1'b0);
      issue(2, 1'b0, 16'h0002, 16'h0202, 16'h0000, 1'b0);
      @(negedge clock);
      req[2] = 1'b1; rd[2] = 1'b1; addr[2] = 16'h0001; din[2] = 16'hFFFF;
      x.id = 2; x.dout = 16'h0101; x.err = 1'b0; x.cyc = cyc + 5; x.blen = 4;
      q.push_back(x);
      x.dout = 16'h0202; x.cyc = cyc + 10;
      q.push_back(x);
      @(negedge clock);
      addr[2] = 16'h0002;
      repeat (5) @(negedge clock);
      req[2] = 1'b0;
      wait_drain(2);

      // WAIT_CYCLES=4: reset two edges into a store discards it
      issue(3, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
      issue(3, 1'b0, 16'h0021, 16'h9999, 16'h0000, 1'b0);
      issue(3, 1'b1, 16'h0021, 16'h0000, 16'h9999, 1'b0);
      @(negedge clock);
      req[3] = 1'b1; rd[3] = 1'b0; addr[3] = 16'h0020; din[3] = 16'hCAFE;
      @(negedge clock);
      req[3] = 1'b0;
      @(negedge clock);
      rst_n[3] = 1'b0;
      @(negedge clock);
      chk_idle(3, 16'h0000);
      rst_n[3] = 1'b1;
      repeat (8) @(negedge clock);
      chk_idle(3, 16'h0000);
      issue(3, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0);

      repeat (3) @(negedge clock);
      chk("scoreboard_leftover", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
